// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex; the FIFO takes the slave side
// and the producer/consumer pair drives the master side.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
);
    localparam int CW = $clog2(DATA_DEPTH) + 1;

    logic                  flush;
    logic [DATA_WIDTH-1:0] din;
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  flush, din, write_en, read_en,
        output dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport master (
        output flush, din, write_en, read_en,
        input  dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock elastic FIFO with flush, occupancy flags, overflow/underflow
// pulses and a choice of registered or first-word-fall-through read port.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter bit FWFT       = 1'b0,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    sync_fifo_flex_if.slave bus
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PW-1:0]         wrPtr_q, wrPtr_d;
    logic [PW-1:0]         rdPtr_q, rdPtr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [PW-1:0]         level;
    logic                  isEmpty, isFull;
    logic                  wrAccept, rdAccept;

    // Extra pointer MSB tells a full wrap apart from an empty FIFO.
    assign level    = wrPtr_q - rdPtr_q;
    assign isEmpty  = (wrPtr_q == rdPtr_q);
    assign isFull   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign wrAccept = bus.write_en && !isFull  && !bus.flush;
    assign rdAccept = bus.read_en  && !isEmpty && !bus.flush;

    assign bus.count        = level;
    assign bus.empty        = isEmpty;
    assign bus.full         = isFull;
    assign bus.almost_empty = (level <= AE_LEVEL);
    assign bus.almost_full  = (level >= AF_LEVEL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (bus.flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (wrAccept) wrPtr_d = wrPtr_q + 1'b1;
            if (rdAccept) rdPtr_d = rdPtr_q + 1'b1;
            overflow_d  = bus.write_en && isFull;
            underflow_d = bus.read_en && isEmpty;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wrAccept) mem[wrPtr_q[AW-1:0]] <= bus.din;
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.dout       = mem[rdPtr_q[AW-1:0]];
            assign bus.dout_valid = !isEmpty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  doutValid_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dout_q      <= '0;
                    doutValid_q <= 1'b0;
                end else begin
                    if (rdAccept) dout_q <= mem[rdPtr_q[AW-1:0]];
                    doutValid_q <= rdAccept;
                end
            end

            assign bus.dout       = dout_q;
            assign bus.dout_valid = doutValid_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: a standard-mode FIFO driven against a queue model, plus a
// FWFT instance exercised with hand-computed vectors.
module tb_sync_fifo_flex;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;

    logic [31:0] q [$];
    logic [31:0] expDout;
    logic        expValid, expOvf, expUnf;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DATA_WIDTH(32), .DATA_DEPTH(8)) busA ();
    sync_fifo_flex_if #(.DATA_WIDTH(32), .DATA_DEPTH(8)) busB ();

    sync_fifo_flex #(.DATA_WIDTH(32), .DATA_DEPTH(8), .FWFT(1'b0),
                     .AF_THRESH(6), .AE_THRESH(2))
        dutStd (.clk(clk), .reset_n(reset_n), .bus(busA.slave));

    sync_fifo_flex #(.DATA_WIDTH(32), .DATA_DEPTH(8), .FWFT(1'b1),
                     .AF_THRESH(6), .AE_THRESH(2))
        dutFwft (.clk(clk), .reset_n(reset_n), .bus(busB.slave));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic modelReset();
        q.delete();
        expDout  = '0;
        expValid = 1'b0;
        expOvf   = 1'b0;
        expUnf   = 1'b0;
    endtask

    // Drives one cycle on the standard FIFO, advances the model, returns at edge+1.
    task automatic applyStimulus(input logic we, input logic [31:0] d,
                                 input logic re, input logic fl);
        bit wasFull, wasEmpty;
        wasFull  = (q.size() == 8);
        wasEmpty = (q.size() == 0);
        busA.write_en = we;
        busA.din      = d;
        busA.read_en  = re;
        busA.flush    = fl;
        @(posedge clk);
        #1;
        busA.write_en = 1'b0;
        busA.read_en  = 1'b0;
        busA.flush    = 1'b0;
        if (fl) begin
            q.delete();
            expValid = 1'b0;
            expOvf   = 1'b0;
            expUnf   = 1'b0;
        end else begin
            expOvf = we && wasFull;
            expUnf = re && wasEmpty;
            if (re && !wasEmpty) begin
                expDout  = q.pop_front();
                expValid = 1'b1;
            end else begin
                expValid = 1'b0;
            end
            if (we && !wasFull) q.push_back(d);
        end
    endtask

    task automatic checkAll(input string tag);
        int n;
        n = q.size();
        checkOutput({tag, " count"},        busA.count,        32'(n));
        checkOutput({tag, " empty"},        busA.empty,        32'(n == 0));
        checkOutput({tag, " full"},         busA.full,         32'(n == 8));
        checkOutput({tag, " almost_full"},  busA.almost_full,  32'(n >= 6));
        checkOutput({tag, " almost_empty"}, busA.almost_empty, 32'(n <= 2));
        checkOutput({tag, " dout_valid"},   busA.dout_valid,   32'(expValid));
        checkOutput({tag, " dout"},         busA.dout,         expDout);
        checkOutput({tag, " overflow"},     busA.overflow,     32'(expOvf));
        checkOutput({tag, " underflow"},    busA.underflow,    32'(expUnf));
    endtask

    task automatic fwftStep(input logic we, input logic [31:0] d, input logic re);
        busB.write_en = we;
        busB.din      = d;
        busB.read_en  = re;
        @(posedge clk);
        #1;
        busB.write_en = 1'b0;
        busB.read_en  = 1'b0;
    endtask

    initial begin
        busA.write_en = 1'b0; busA.read_en = 1'b0; busA.flush = 1'b0; busA.din = '0;
        busB.write_en = 1'b0; busB.read_en = 1'b0; busB.flush = 1'b0; busB.din = '0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset fwft empty", busB.empty, 32'd1);
        checkOutput("reset fwft dout_valid", busB.dout_valid, 32'd0);

        // In-order fill and drain.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i * 8'h11), 1'b0, 1'b0);
            checkAll("t1 write");
        end
        checkOutput("t1 full after 8", busA.full, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll("t1 read");
            checkOutput("t1 read data", busA.dout, 32'(i * 8'h11));
        end
        checkOutput("t1 empty after 8", busA.empty, 32'd1);

        // Simultaneous requests at the full and empty boundaries.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            checkAll("t2 fill");
        end
        applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b0);
        checkAll("t2 both full");
        checkOutput("t2 head", busA.dout, 32'h100);
        checkOutput("t2 overflow", busA.overflow, 32'd1);
        checkOutput("t2 count", busA.count, 32'd7);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t2 overflow single", busA.overflow, 32'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll("t2 drain");
        end
        checkOutput("t2 last of batch", busA.dout, 32'h107);
        applyStimulus(1'b1, 32'hBEEF, 1'b1, 1'b0);
        checkAll("t2 both empty");
        checkOutput("t2 underflow", busA.underflow, 32'd1);
        checkOutput("t2 count one", busA.count, 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkAll("t2 pop");
        checkOutput("t2 pop data", busA.dout, 32'hBEEF);

        // Occupancy sweep up and down.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
            checkAll("t3 up");
        end
        applyStimulus(1'b1, 32'hBAD, 1'b0, 1'b0);
        checkAll("t3 overflow only");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll("t3 down");
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkAll("t3 underflow only");

        // Interleaved traffic across pointer wrap.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
            checkAll("t4 prime");
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(i), 1'b1, 1'b0);
            checkAll("t4 pair");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkAll("t4 drain");
        end
        checkOutput("t4 final data", busA.dout, 32'h413);

        // Async reset mid-cycle, then flush.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        checkOutput("t6 count five", busA.count, 32'd5);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("t6 async reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("t6 after reset");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0);
        checkAll("t6 refill");
        checkOutput("t6 count four", busA.count, 32'd4);
        applyStimulus(1'b1, 32'h777, 1'b1, 1'b1);
        checkAll("t6 flush");
        checkOutput("t6 flush dout held", busA.dout, 32'h600);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkAll("t6 read after flush");

        // FWFT instance.
        fwftStep(1'b1, 32'hA5, 1'b0);
        checkOutput("t5 dout", busB.dout, 32'hA5);
        checkOutput("t5 valid", busB.dout_valid, 32'd1);
        fwftStep(1'b0, '0, 1'b0);
        checkOutput("t5 held valid", busB.dout_valid, 32'd1);
        checkOutput("t5 held dout", busB.dout, 32'hA5);
        fwftStep(1'b0, '0, 1'b1);
        checkOutput("t5 empty after pop", busB.empty, 32'd1);
        checkOutput("t5 valid after pop", busB.dout_valid, 32'd0);
        fwftStep(1'b1, 32'h3C, 1'b0);
        fwftStep(1'b1, 32'h5A, 1'b0);
        checkOutput("t5 head first", busB.dout, 32'h3C);
        checkOutput("t5 count two", busB.count, 32'd2);
        fwftStep(1'b0, '0, 1'b1);
        checkOutput("t5 head second", busB.dout, 32'h5A);
        fwftStep(1'b0, '0, 1'b1);
        fwftStep(1'b0, '0, 1'b1);
        checkOutput("t5 underflow", busB.underflow, 32'd1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
